knock_pattern_tx: RTL and testbench
===================================

// Module: knock_pattern_tx
// PURPOSE
//  Transmit side of the knock interface: taps a stored knock pattern onto a solenoid actuator
//  so a knock sensor input can be exercised. Sits beside the safe unlock logic on CLOCK_50.
//  Control logic loads a pattern (knock count plus inter-knock gap codes) and pulses start.
//  The block then plays fixed-width solenoid pulses separated by the coded gaps.
// PARAMETERS
//  CLK_HZ       50_000_000  clock frequency in Hz
//  MAX_KNOCKS   8           maximum knocks per pattern
//  GAP_W        4           bits per gap code
//  PULSE_MS     20          solenoid on-time per knock, in ms
//  GAP_UNIT_MS  50          gap time per code LSB, in ms
//  Derived: PULSE_CYC = CLK_HZ/1000*PULSE_MS; UNIT_CYC = CLK_HZ/1000*GAP_UNIT_MS.
// PORTS
//  CLOCK_50      in   1                     system clock
//  reset_n       in   1                     asynchronous reset, active-low
//  start         in   1                     begin playback; sampled only in IDLE
//  knock_count   in   4                     number of knocks, clamped to MAX_KNOCKS
//  gap_codes     in   MAX_KNOCKS*GAP_W      gap i in bits [i*GAP_W +: GAP_W]; gap i follows knock i
//  solenoid_out  out  1                     high = solenoid energised (one knock)
//  busy          out  1                     high while a pattern is playing
//  done          out  1                     one-cycle pulse when playback completes
// BEHAVIOUR
//  - Reset (async assert, sync deassert sampling): state=IDLE; solenoid_out=0, busy=0, done=0.
//    All counters and latched pattern registers are cleared.
//  - All outputs are registered.
//  - States: IDLE, PULSE, GAP, FINISH.
//  - IDLE: when start=1 at edge t, latch knock_count and gap_codes, and clear knock index k=0.
//    If the clamped count is 0, go to FINISH. Otherwise go to PULSE with solenoid_out=1 and busy=1
//    from cycle t+1 (1-cycle latency).
//  - PULSE: solenoid_out=1 for exactly PULSE_CYC cycles.
//    If k was the last knock, go to FINISH; otherwise go to GAP.
//  - GAP: solenoid_out=0 for max(1, code_k*UNIT_CYC) cycles; code 0 gives a 1-cycle minimum gap.
//    Then k++ and go to PULSE.
//  - FINISH: for one cycle, done=1 and busy=0, then go to IDLE.
//    The gap after the final knock is never played.
//  - start during PULSE/GAP/FINISH is ignored. Latched pattern inputs may change freely after start.
//  - knock_count > MAX_KNOCKS is treated as MAX_KNOCKS.
//  - Timer width: $clog2 of max(PULSE_CYC, (2**GAP_W-1)*UNIT_CYC)+1; the timer must not wrap.
//  - Reset mid-pattern: solenoid_out drops asynchronously, and no done pulse is emitted.
// CONFIGURATION
//  KNOCK_TX_ABORT_EN defined: adds input port abort (1 bit).
//   - abort=1 in PULSE or GAP: solenoid_out=0 and busy=0 next cycle, state returns to IDLE, no done.
//   - An additional output aborted pulses 1 cycle at the same time.
//   - abort has priority over normal transitions in that cycle; abort in IDLE/FINISH is ignored.
//  KNOCK_TX_ABORT_EN undefined: neither port exists; a pattern always plays to completion unless reset.
// TESTING  (CLK_HZ=1000, PULSE_MS=2, GAP_UNIT_MS=3 -> PULSE_CYC=2, UNIT_CYC=3; start at edge 0)
//  1 count=3, gaps={1,2}: solenoid high cycles 1-2, 6-7, 14-15; low 3-5, 8-13; done=1 at cycle 16 only.
//  2 count=0: no solenoid pulse, busy stays 0, done=1 at cycle 1.
//  3 count=2, gap0=0: solenoid high 1-2, low 3, high 4-5, done at 6.
//  4 count=15 (MAX_KNOCKS=8), all gaps=1: exactly 8 pulses; start pulses mid-play are ignored (still 8).
//  5 reset_n low at cycle 7 of test 1: solenoid_out/busy go 0 immediately, no done; restart replays fully.
//  6 [KNOCK_TX_ABORT_EN] abort at cycle 4 of test 1: aborted=1 and busy=0 at cycle 5, no more pulses, no done.

Source files
------------

// File: rtl/knock_pattern_tx.sv
// Knock pattern transmitter: plays a latched knock pattern as fixed-width solenoid pulses separated by coded gaps.
// Optional abort input/aborted output are enabled by defining KNOCK_TX_ABORT_EN.
module knock_pattern_tx #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned MAX_KNOCKS  = 8,
  parameter int unsigned GAP_W       = 4,
  parameter int unsigned PULSE_MS    = 20,
  parameter int unsigned GAP_UNIT_MS = 50
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [3:0]                    knock_count,
  input  logic [MAX_KNOCKS*GAP_W-1:0]   gap_codes,
`ifdef KNOCK_TX_ABORT_EN
  input  logic                          abort,
  output logic                          aborted,
`endif
  output logic                          solenoid_out,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned PULSE_CYC = CLK_HZ / 1000 * PULSE_MS;
  localparam int unsigned UNIT_CYC  = CLK_HZ / 1000 * GAP_UNIT_MS;
  localparam int unsigned GAP_MAX   = ((2 ** GAP_W) - 1) * UNIT_CYC;
  localparam int unsigned TIME_MAX  = (PULSE_CYC > GAP_MAX) ? PULSE_CYC : GAP_MAX;
  localparam int unsigned TIMER_W   = $clog2(TIME_MAX + 1);
  localparam int unsigned PAT_W     = MAX_KNOCKS * GAP_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYC - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           k_q, k_d;
  logic [3:0]           count_q, count_d;
  logic [PAT_W-1:0]     gaps_q, gaps_d;
  logic                 solenoid_q, solenoid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef KNOCK_TX_ABORT_EN
  logic                 aborted_q, aborted_d;
`endif

  logic [3:0]           clamp_c;
  logic [TIMER_W-1:0]   gap_cyc_c;
  logic [TIMER_W-1:0]   gap_load_c;

  // Current gap code always sits in the low slot; the latched pattern shifts down after each gap.
  always_comb begin
    clamp_c    = (32'(knock_count) > MAX_KNOCKS) ? 4'(MAX_KNOCKS) : knock_count;
    gap_cyc_c  = TIMER_W'(gaps_q[GAP_W-1:0]) * TIMER_W'(UNIT_CYC);
    gap_load_c = (gap_cyc_c == '0) ? '0 : gap_cyc_c - TIMER_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    k_d        = k_q;
    count_d    = count_q;
    gaps_d     = gaps_q;
    solenoid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef KNOCK_TX_ABORT_EN
    aborted_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = clamp_c;
          gaps_d  = gap_codes;
          k_d     = 4'd0;
          if (clamp_c == 4'd0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = PULSE;
            timer_d    = PULSE_LOAD;
            solenoid_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      PULSE: begin
        busy_d = 1'b1;
        if (timer_q == '0) begin
          if (k_q == count_q - 4'd1) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            timer_d = gap_load_c;
          end
        end else begin
          timer_d    = timer_q - TIMER_W'(1);
          solenoid_d = 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (timer_q == '0) begin
          state_d    = PULSE;
          k_d        = k_q + 4'd1;
          gaps_d     = gaps_q >> GAP_W;
          timer_d    = PULSE_LOAD;
          solenoid_d = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef KNOCK_TX_ABORT_EN
    // Abort overrides whatever the playing states decided this cycle.
    if (abort && (state_q == PULSE || state_q == GAP)) begin
      state_d    = IDLE;
      timer_d    = '0;
      solenoid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      aborted_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      k_q        <= 4'd0;
      count_q    <= 4'd0;
      gaps_q     <= '0;
      solenoid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef KNOCK_TX_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      k_q        <= k_d;
      count_q    <= count_d;
      gaps_q     <= gaps_d;
      solenoid_q <= solenoid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef KNOCK_TX_ABORT_EN
      aborted_q  <= aborted_d;
`endif
    end
  end

  assign solenoid_out = solenoid_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef KNOCK_TX_ABORT_EN
  assign aborted      = aborted_q;
`endif

endmodule

// File: tb/tb_knock_pattern_tx.sv
// Testbench for knock_pattern_tx: table vectors, random patterns against a trace model, reset/abort sequences.
module tb_knock_pattern_tx;

  localparam int unsigned CLK_HZ      = 1000;
  localparam int unsigned MAX_KNOCKS  = 8;
  localparam int unsigned GAP_W       = 4;
  localparam int unsigned PULSE_MS    = 2;
  localparam int unsigned GAP_UNIT_MS = 3;
  localparam int          PULSE_CYC   = 2;
  localparam int          UNIT_CYC    = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  knock_count;
  logic [31:0] gap_codes;
  logic        solenoid_out;
  logic        busy;
  logic        done;
`ifdef KNOCK_TX_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int tests_run;
  int tests_failed;

  knock_pattern_tx #(
    .CLK_HZ(CLK_HZ), .MAX_KNOCKS(MAX_KNOCKS), .GAP_W(GAP_W),
    .PULSE_MS(PULSE_MS), .GAP_UNIT_MS(GAP_UNIT_MS)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(rst_n),
    .start(start),
    .knock_count(knock_count),
    .gap_codes(gap_codes),
`ifdef KNOCK_TX_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .solenoid_out(solenoid_out),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cnt;
    logic [31:0] gaps;
    bit          noise;
    int          done_cyc;
    int          pulses;
    logic [63:0] sol_map;
  } vec_t;

  task automatic check(input string name, input int cyc, input logic [2:0] act, input logic [2:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: sol/busy/done got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected per-cycle {solenoid, busy, done} trace, built from knock/gap durations.
  task automatic build_trace(input logic [3:0] cnt, input logic [31:0] gaps, output logic [2:0] q[$]);
    int n;
    int g;
    int len;
    q = {};
    n = (int'(cnt) > MAX_KNOCKS) ? MAX_KNOCKS : int'(cnt);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < PULSE_CYC; p++) q.push_back(3'b110);
      if (i < n - 1) begin
        g   = int'(gaps[i*4 +: 4]);
        len = (g == 0) ? 1 : g * UNIT_CYC;
        for (int p = 0; p < len; p++) q.push_back(3'b010);
      end
    end
    q.push_back(3'b001);
  endtask

  // Starts a pattern at the next edge and compares every cycle against the model trace.
  task automatic run_pat(input string name, input logic [3:0] cnt, input logic [31:0] gaps,
                         input bit noise, output int done_cyc, output int pulses,
                         output logic [63:0] sol_map);
    logic [2:0] q[$];
    logic [2:0] exp;
    logic [2:0] act;
    logic       prev;
    int         sz;
    build_trace(cnt, gaps, q);
    sz       = q.size();
    done_cyc = -1;
    pulses   = 0;
    sol_map  = '0;
    prev     = 1'b0;
    @(negedge clk);
    start       = 1'b1;
    knock_count = cnt;
    gap_codes   = gaps;
    @(posedge clk);
    for (int c = 1; c <= sz + 2; c++) begin
      @(negedge clk);
      act = {solenoid_out, busy, done};
      exp = (c <= sz) ? q[c-1] : 3'b000;
      check(name, c, act, exp);
      if (solenoid_out && !prev) pulses++;
      prev = solenoid_out;
      if (done && done_cyc < 0) done_cyc = c;
      if (c < 64) sol_map[c] = solenoid_out;
      knock_count = 4'($urandom);
      gap_codes   = $urandom;
      start       = (noise && c < sz) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  vec_t        vecs[4];
  int          dc;
  int          np;
  logic [63:0] sm;
  logic [3:0]  rc;
  logic [31:0] rg;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    knock_count  = 4'd0;
    gap_codes    = 32'd0;
`ifdef KNOCK_TX_ABORT_EN
    abort        = 1'b0;
`endif

    vecs[0] = '{cnt: 4'd3,  gaps: 32'h0000_0021, noise: 1'b0, done_cyc: 16, pulses: 3, sol_map: 64'h0000_0000_0000_C0C6};
    vecs[1] = '{cnt: 4'd0,  gaps: 32'h0000_0021, noise: 1'b0, done_cyc: 1,  pulses: 0, sol_map: 64'h0};
    vecs[2] = '{cnt: 4'd2,  gaps: 32'h0000_0000, noise: 1'b0, done_cyc: 6,  pulses: 2, sol_map: 64'h0000_0000_0000_0036};
    vecs[3] = '{cnt: 4'd15, gaps: 32'h1111_1111, noise: 1'b1, done_cyc: 38, pulses: 8, sol_map: 64'h0000_0031_8C63_18C6};

    repeat (2) @(negedge clk);
    check("reset_state", 0, {solenoid_out, busy, done}, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_pat($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].gaps, vecs[i].noise, dc, np, sm);
      check_int($sformatf("vec%0d_done_cycle", i), dc, vecs[i].done_cyc);
      check_int($sformatf("vec%0d_pulses", i), np, vecs[i].pulses);
      tests_run++;
      if (sm !== vecs[i].sol_map) begin
        tests_failed++;
        $display("FAIL vec%0d_sol_map: got %h expected %h", i, sm, vecs[i].sol_map);
      end
    end

    // Reset in the middle of the second knock, then a full replay.
    @(negedge clk);
    start       = 1'b1;
    knock_count = 4'd3;
    gap_codes   = 32'h21;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset", 7, {solenoid_out, busy, done}, 3'b110);
    rst_n = 1'b0;
    #1;
    check("async_reset", 7, {solenoid_out, busy, done}, 3'b000);
    for (int c = 8; c < 28; c++) begin
      @(negedge clk);
      if (c == 10) rst_n = 1'b1;
      check("after_reset", c, {solenoid_out, busy, done}, 3'b000);
    end
    run_pat("replay", 4'd3, 32'h21, 1'b0, dc, np, sm);
    check_int("replay_done_cycle", dc, 16);

`ifdef KNOCK_TX_ABORT_EN
    // Abort sampled at the end of cycle 4 takes effect in cycle 5.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("abort_idle", 0, {aborted, busy, done}, 3'b000);
    abort       = 1'b0;
    start       = 1'b1;
    knock_count = 4'd3;
    gap_codes   = 32'h21;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pulse", 5, {aborted, busy, solenoid_out}, 3'b100);
    for (int c = 6; c < 26; c++) begin
      @(negedge clk);
      check("after_abort", c, {solenoid_out | aborted, busy, done}, 3'b000);
    end
`endif

    for (int r = 0; r < 25; r++) begin
      rc = 4'($urandom);
      rg = $urandom;
      run_pat($sformatf("rand%0d", r), rc, rg, 1'($urandom_range(0, 1)), dc, np, sm);
      check_int($sformatf("rand%0d_pulses", r), np, (int'(rc) > 8) ? 8 : int'(rc));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
